// File: rtl/async_receiver_if.sv
// Receive-side bundle: the raw serial line plus the byte/strobe outputs
// offered to the consumer logic.
`timescale 1ns/1ps

interface async_receiver_if;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_error;
    logic       RxD_idle;

    modport master (
        input  RxD,
        output RxD_data,
        output RxD_data_ready,
        output RxD_frame_error,
        output RxD_idle
    );

    modport slave (
        output RxD,
        input  RxD_data,
        input  RxD_data_ready,
        input  RxD_frame_error,
        input  RxD_idle
    );
endinterface

// File: rtl/async_receiver.sv
// 8N1 UART receiver: oversampled, majority-voted bit recovery with a
// one-cycle ready strobe per good byte and a one-cycle frame-error strobe.
`timescale 1ns/1ps

module async_receiver #(
    parameter int FREQ       = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    async_receiver_if.master  rx
);

    localparam int DIV   = FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0]  SC_S0    = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_S1    = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0]  SC_DEC   = SC_W'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } stateT;

    stateT            state;
    logic             rxMeta;
    logic             rxSync;
    logic [DIV_W-1:0] divCnt;
    logic             tick;
    logic [SC_W-1:0]  sampleCnt;
    logic [SC_W-1:0]  nextSample;
    logic             sampleWrap;
    logic             decide;
    logic             s0;
    logic             s1;
    logic             majority;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;

    // Two-flop synchroniser; resets to the idle (high) line level.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rx.RxD;
            rxSync <= rxMeta;
        end
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            divCnt <= '0;
        end else if (tick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign tick = (divCnt == DIV_LAST);

    // sampleCnt holds the index of the most recent sample within the bit;
    // the tick that detects the start edge is sample 0 of the start bit.
    assign nextSample = (sampleCnt == SC_LAST) ? '0 : sampleCnt + 1'b1;
    assign sampleWrap = tick && (sampleCnt == SC_LAST);
    assign decide     = tick && (nextSample == SC_DEC);
    assign majority   = (s0 & s1) | (s0 & rxSync) | (s1 & rxSync);

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state              <= IDLE;
            sampleCnt          <= '0;
            s0                 <= 1'b0;
            s1                 <= 1'b0;
            bitIdx             <= '0;
            shiftReg           <= '0;
            rx.RxD_data        <= '0;
            rx.RxD_data_ready  <= 1'b0;
            rx.RxD_frame_error <= 1'b0;
            rx.RxD_idle        <= 1'b1;
        end else begin
            rx.RxD_data_ready  <= 1'b0;
            rx.RxD_frame_error <= 1'b0;

            if (tick) begin
                sampleCnt <= nextSample;
                if (nextSample == SC_S0) s0 <= rxSync;
                if (nextSample == SC_S1) s1 <= rxSync;
            end

            case (state)
                IDLE: begin
                    if (tick && !rxSync) begin
                        state       <= START;
                        sampleCnt   <= '0;
                        rx.RxD_idle <= 1'b0;
                    end else begin
                        rx.RxD_idle <= 1'b1;
                    end
                end

                START: begin
                    if (decide && majority) begin
                        state <= IDLE;
                    end else if (sampleWrap) begin
                        state  <= DATA;
                        bitIdx <= '0;
                    end
                end

                DATA: begin
                    if (decide) shiftReg[bitIdx] <= majority;
                    if (sampleWrap) begin
                        if (bitIdx == 3'd7) state  <= STOP;
                        else                bitIdx <= bitIdx + 1'b1;
                    end
                end

                // Leave half a bit early on a good stop so a back-to-back
                // start edge is already watched for in IDLE.
                STOP: begin
                    if (decide) begin
                        if (majority) begin
                            rx.RxD_data       <= shiftReg;
                            rx.RxD_data_ready <= 1'b1;
                            state             <= IDLE;
                        end else begin
                            rx.RxD_frame_error <= 1'b1;
                            state              <= WAIT_HIGH;
                        end
                    end
                end

                WAIT_HIGH: begin
                    if (tick && rxSync) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_async_receiver.sv
// Directed bench for async_receiver: drives serial frames at nominal and
// skewed rates and checks strobes, data and idle flag against fixed values.
`timescale 1ns/1ps

module tb_async_receiver;

    localparam int BIT_NS  = 8680;
    localparam int FAST_NS = 8463;
    localparam int SLOW_NS = 8897;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxLine = 1'b1;

    int nChecks = 0;
    int nFails  = 0;
    int readyCnt = 0;
    int errCnt   = 0;
    int bothCnt  = 0;
    int rxQ[$];

    async_receiver_if rxIf();
    assign rxIf.RxD = rxLine;

    async_receiver dut (
        .CLK50MHZ (clk),
        .RST      (rst),
        .rx       (rxIf)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rxIf.RxD_data_ready) begin
                readyCnt++;
                rxQ.push_back(int'(rxIf.RxD_data));
            end
            if (rxIf.RxD_frame_error) errCnt++;
            if (rxIf.RxD_data_ready && rxIf.RxD_frame_error) bothCnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input int bitNs, input logic stopVal);
        rxLine = 1'b0;
        #(bitNs);
        for (int i = 0; i < 8; i++) begin
            rxLine = b[i];
            #(bitNs);
        end
        rxLine = stopVal;
        #(bitNs);
    endtask

    int rSnap;
    int eSnap;

    initial begin
        #3;
        repeat (5) @(posedge clk);
        settle();
        check("reset_data",  32'(rxIf.RxD_data), 32'h00);
        check("reset_ready", 32'(rxIf.RxD_data_ready), 32'h0);
        check("reset_err",   32'(rxIf.RxD_frame_error), 32'h0);
        check("reset_idle",  32'(rxIf.RxD_idle), 32'h1);
        rst = 1'b0;
        #(BIT_NS);

        // Single byte at nominal rate
        fork
            sendFrame(8'h55, BIT_NS, 1'b1);
            begin
                #(3 * BIT_NS);
                settle();
                check("single_idle_busy", 32'(rxIf.RxD_idle), 32'h0);
            end
        join
        #(BIT_NS);
        settle();
        check("single_ready_cnt", 32'(readyCnt), 32'd1);
        check("single_data", 32'(rxIf.RxD_data), 32'h55);
        check("single_err_cnt", 32'(errCnt), 32'd0);
        check("single_idle", 32'(rxIf.RxD_idle), 32'h1);

        // Back-to-back stream, first half slow, second half fast
        rxQ.delete();
        sendFrame(8'h00, SLOW_NS, 1'b1);
        sendFrame(8'hFF, SLOW_NS, 1'b1);
        sendFrame(8'hA5, FAST_NS, 1'b1);
        sendFrame(8'h3C, FAST_NS, 1'b1);
        #(BIT_NS);
        settle();
        check("b2b_count", 32'(rxQ.size()), 32'd4);
        check("b2b_0", (rxQ.size() > 0) ? 32'(rxQ[0]) : 32'hDEAD, 32'h00);
        check("b2b_1", (rxQ.size() > 1) ? 32'(rxQ[1]) : 32'hDEAD, 32'hFF);
        check("b2b_2", (rxQ.size() > 2) ? 32'(rxQ[2]) : 32'hDEAD, 32'hA5);
        check("b2b_3", (rxQ.size() > 3) ? 32'(rxQ[3]) : 32'hDEAD, 32'h3C);
        check("b2b_err_cnt", 32'(errCnt), 32'd0);

        // 3 us glitch on an idle line
        rSnap = readyCnt;
        eSnap = errCnt;
        rxLine = 1'b0;
        #2000;
        settle();
        check("glitch_left_idle", 32'(rxIf.RxD_idle), 32'h0);
        #999;
        rxLine = 1'b1;
        #(2 * BIT_NS);
        settle();
        check("glitch_idle", 32'(rxIf.RxD_idle), 32'h1);
        check("glitch_ready", 32'(readyCnt - rSnap), 32'd0);
        check("glitch_err", 32'(errCnt - eSnap), 32'd0);
        check("glitch_data", 32'(rxIf.RxD_data), 32'h3C);

        // Stop bit forced low
        rSnap = readyCnt;
        eSnap = errCnt;
        sendFrame(8'h81, BIT_NS, 1'b0);
        rxLine = 1'b1;
        #(2 * BIT_NS);
        settle();
        check("ferr_err", 32'(errCnt - eSnap), 32'd1);
        check("ferr_ready", 32'(readyCnt - rSnap), 32'd0);
        check("ferr_data", 32'(rxIf.RxD_data), 32'h3C);

        // Break: line low for five frame times
        eSnap = errCnt;
        rxLine = 1'b0;
        #(50 * BIT_NS);
        rxLine = 1'b1;
        #(2 * BIT_NS);
        settle();
        check("break_err", 32'(errCnt - eSnap), 32'd1);
        check("break_ready", 32'(readyCnt - rSnap), 32'd0);
        check("break_idle", 32'(rxIf.RxD_idle), 32'h1);

        sendFrame(8'h42, BIT_NS, 1'b1);
        #(BIT_NS);
        settle();
        check("after_break_ready", 32'(readyCnt - rSnap), 32'd1);
        check("after_break_data", 32'(rxIf.RxD_data), 32'h42);

        // Reset after data bit 3 of 8'hC3
        rSnap = readyCnt;
        eSnap = errCnt;
        fork
            sendFrame(8'hC3, BIT_NS, 1'b1);
            begin
                #(5 * BIT_NS);
                rst = 1'b1;
                settle();
                check("rst_mid_data",  32'(rxIf.RxD_data), 32'h00);
                check("rst_mid_ready", 32'(rxIf.RxD_data_ready), 32'h0);
                check("rst_mid_err",   32'(rxIf.RxD_frame_error), 32'h0);
                check("rst_mid_idle",  32'(rxIf.RxD_idle), 32'h1);
                repeat (2) @(posedge clk);
                rst = 1'b0;
            end
        join
        check("rst_frame_ready", 32'(readyCnt - rSnap), 32'd0);
        check("rst_frame_err",   32'(errCnt - eSnap), 32'd0);
        // The low tail of the aborted frame is taken as a fresh start;
        // let it run out before the next frame.
        #(12 * BIT_NS);
        rSnap = readyCnt;
        sendFrame(8'h18, BIT_NS, 1'b1);
        #(BIT_NS);
        settle();
        check("post_rst_ready", 32'(readyCnt - rSnap), 32'd1);
        check("post_rst_data", 32'(rxIf.RxD_data), 32'h18);
        check("post_rst_idle", 32'(rxIf.RxD_idle), 32'h1);

        check("never_both", 32'(bothCnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
